// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto one memory port; grant 1 edge after request, Done 1 edge after MemReady.
// Backpressure: MemReady=0 holds the access indefinitely; data yields to a fetch after MAX_DATA_STREAK grants.
module mem_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic        Clock,
  input  logic        NReset,
  input  logic        IReq,
  input  logic [31:0] IAddress,
  output logic        IDone,
  output logic [31:0] IData,
  input  logic        DReq,
  input  logic        DWrite,
  input  logic [31:0] DAddress,
  input  logic [31:0] DWriteData,
  output logic        DDone,
  output logic [31:0] DReadData,
  output logic        MemRequest,
  output logic        MemWrite,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  input  logic        MemReady,
  input  logic [31:0] MemReadData,
  output logic        Busy
);

  typedef enum logic [1:0] {IDLE, INST, DATA} state_t;

  localparam logic [3:0] MAX_STREAK = 4'(MAX_DATA_STREAK);

  state_t     state;
  logic [3:0] streak;
  logic       turnaround;
  logic       i_elig;
  logic       d_elig;
  logic       grant_d;
  logic       grant_i;

  // The completion cycle is a turnaround: nobody is granted while a Done is
  // high, which gives one idle cycle between Done and the next MemRequest.
  assign turnaround = IDone | DDone;
  assign i_elig     = IReq & ~turnaround;
  assign d_elig     = DReq & ~turnaround;
  assign grant_d    = d_elig & (~i_elig | (streak < MAX_STREAK));
  assign grant_i    = i_elig & (~d_elig | (streak == MAX_STREAK));

  always_ff @(posedge Clock or negedge NReset) begin
    if (!NReset) begin
      state        <= IDLE;
      streak       <= 4'd0;
      MemRequest   <= 1'b0;
      MemWrite     <= 1'b0;
      MemAddress   <= 32'd0;
      MemWriteData <= 32'd0;
      IDone        <= 1'b0;
      IData        <= 32'd0;
      DDone        <= 1'b0;
      DReadData    <= 32'd0;
      Busy         <= 1'b0;
    end else begin
      IDone <= 1'b0;
      DDone <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state        <= DATA;
            Busy         <= 1'b1;
            MemRequest   <= 1'b1;
            MemAddress   <= DAddress;
            MemWrite     <= DWrite;
            MemWriteData <= DWriteData;
            if (!IReq)
              streak <= 4'd0;
            else if (streak != MAX_STREAK)
              streak <= streak + 4'd1;
          end else if (grant_i) begin
            state      <= INST;
            Busy       <= 1'b1;
            MemRequest <= 1'b1;
            MemAddress <= IAddress;
            MemWrite   <= 1'b0;
            streak     <= 4'd0;
          end
        end
        INST: begin
          if (MemReady) begin
            state      <= IDLE;
            Busy       <= 1'b0;
            MemRequest <= 1'b0;
            MemWrite   <= 1'b0;
            IDone      <= 1'b1;
            IData      <= MemReadData;
          end
        end
        DATA: begin
          if (MemReady) begin
            state      <= IDLE;
            Busy       <= 1'b0;
            MemRequest <= 1'b0;
            MemWrite   <= 1'b0;
            DDone      <= 1'b1;
            // MemWrite still holds the latched direction of this access.
            DReadData  <= MemWrite ? 32'd0 : MemReadData;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus queues expected grants/completions, a monitor checks them.
module tb_mem_arbiter;

  logic        Clock = 1'b0;
  logic        NReset;
  logic        IReq;
  logic [31:0] IAddress;
  logic        IDone;
  logic [31:0] IData;
  logic        DReq;
  logic        DWrite;
  logic [31:0] DAddress;
  logic [31:0] DWriteData;
  logic        DDone;
  logic [31:0] DReadData;
  logic        MemRequest;
  logic        MemWrite;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        MemReady = 1'b0;
  logic [31:0] MemReadData = 32'd0;
  logic        Busy;

  mem_arbiter #(.MAX_DATA_STREAK(4)) dut (
    .Clock(Clock), .NReset(NReset),
    .IReq(IReq), .IAddress(IAddress), .IDone(IDone), .IData(IData),
    .DReq(DReq), .DWrite(DWrite), .DAddress(DAddress), .DWriteData(DWriteData),
    .DDone(DDone), .DReadData(DReadData),
    .MemRequest(MemRequest), .MemWrite(MemWrite), .MemAddress(MemAddress),
    .MemWriteData(MemWriteData), .MemReady(MemReady), .MemReadData(MemReadData),
    .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
  } done_t;

  gnt_t  gnt_q[$];
  done_t done_q[$];
  gnt_t  cur_g;
  gnt_t  mon_g;
  done_t mon_d;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event want none (t=%0t)", name, $time);
  endtask

  task automatic push_g(input bit is_d, input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
    gnt_t g;
    g.is_d = is_d; g.addr = addr; g.wr = wr; g.wdata = wdata;
    gnt_q.push_back(g);
  endtask

  task automatic push_d(input bit is_d, input logic [31:0] data);
    done_t d;
    d.is_d = is_d; d.data = data;
    done_q.push_back(d);
  endtask

  // Memory model: either MemReady tied high, or asserted after mem_delay waiting cycles.
  bit tie_high = 1'b0;
  int mem_delay = 0;
  int wait_cnt = 0;

  function automatic logic [31:0] rfn(input logic [31:0] a);
    if (a == 32'h0040_0010) return 32'h8C08_0004;
    return a ^ 32'h5A5A_0000;
  endfunction

  always @(negedge Clock) begin
    MemReadData = rfn(MemAddress);
    if (tie_high) begin
      MemReady = 1'b1;
    end else if (MemRequest) begin
      MemReady = (wait_cnt == mem_delay);
      wait_cnt++;
    end else begin
      MemReady = 1'b0;
      wait_cnt = 0;
    end
  end

  // Monitor
  bit prev_req = 1'b0;
  bit prev_done = 1'b0;

  always @(negedge Clock) begin
    if (!NReset) begin
      prev_req  = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (MemRequest && !prev_req) begin
        if (gnt_q.size() == 0) fail("unexpected_grant");
        else begin
          mon_g = gnt_q.pop_front();
          cur_g = mon_g;
          chk("grant_addr", MemAddress, mon_g.addr);
          chk("grant_wr", MemWrite, mon_g.wr);
          if (mon_g.wr) chk("grant_wdata", MemWriteData, mon_g.wdata);
          chk("grant_busy", Busy, 1);
        end
      end else if (MemRequest) begin
        chk("hold_addr", MemAddress, cur_g.addr);
        chk("hold_wr", MemWrite, cur_g.wr);
      end
      if (IDone || DDone) begin
        chk("done_gap", prev_done, 0);
        chk("done_single", IDone & DDone, 0);
        chk("done_memreq", MemRequest, 0);
        if (done_q.size() == 0) fail("unexpected_done");
        else begin
          mon_d = done_q.pop_front();
          chk("done_kind", DDone, mon_d.is_d);
          chk("done_data", mon_d.is_d ? DReadData : IData, mon_d.data);
        end
      end
      prev_req  = MemRequest;
      prev_done = IDone | DDone;
    end
  end

  task automatic wait_done(input bit is_d, input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge Clock);
      seen = is_d ? DDone : IDone;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: got no Done want Done within 50 cycles", name);
    end
  endtask

  initial begin
    int wr_cycles;
    int dones;
    bit got;

    NReset = 1'b0; IReq = 1'b0; IAddress = 32'd0;
    DReq = 1'b0; DWrite = 1'b0; DAddress = 32'd0; DWriteData = 32'd0;
    repeat (3) @(negedge Clock);
    chk("rst_memreq", MemRequest, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_idone", IDone, 0);
    chk("rst_ddone", DDone, 0);
    chk("rst_memaddr", MemAddress, 0);
    NReset = 1'b1;

    // Fetch with MemReady tied high; idle cycles with MemReady high must do nothing.
    tie_high = 1'b1;
    repeat (3) @(negedge Clock);
    chk("idle_ready_busy", Busy, 0);
    push_g(0, 32'h0040_0010, 0, 32'd0);
    push_d(0, 32'h8C08_0004);
    IAddress = 32'h0040_0010;
    IReq = 1'b1;
    @(negedge Clock);
    chk("fetch_lat_req", MemRequest, 1);
    chk("fetch_lat_addr", MemAddress, 32'h0040_0010);
    @(negedge Clock);
    chk("fetch_idone", IDone, 1);
    chk("fetch_idata", IData, 32'h8C08_0004);
    IReq = 1'b0;
    repeat (3) @(negedge Clock);
    chk("idle_after_busy", Busy, 0);

    // Store with MemReady delayed 3 cycles.
    tie_high = 1'b0;
    mem_delay = 3;
    push_g(1, 32'h1001_0000, 1, 32'hDEAD_BEEF);
    push_d(1, 32'd0);
    DAddress = 32'h1001_0000; DWrite = 1'b1; DWriteData = 32'hDEAD_BEEF;
    DReq = 1'b1;
    wr_cycles = 0;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge Clock);
      if (MemWrite) wr_cycles++;
      got = DDone;
    end
    DReq = 1'b0;
    chk("store_ddone_seen", got, 1);
    chk("store_wr_cycles", wr_cycles, 4);
    chk("store_dreaddata", DReadData, 0);

    // Read with one wait cycle; IData must still hold the earlier fetch word.
    @(negedge Clock);
    mem_delay = 1;
    push_g(1, 32'h1001_0004, 0, 32'd0);
    push_d(1, 32'h4A5B_0004);
    DAddress = 32'h1001_0004; DWrite = 1'b0; DWriteData = 32'h0;
    DReq = 1'b1;
    wait_done(1, "read_done");
    DReq = 1'b0;
    chk("idata_hold", IData, 32'h8C08_0004);

    // Contention: expect D,D,D,D,I,D,D,D,D,I.
    @(negedge Clock);
    tie_high = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) begin
        push_g(0, 32'h0040_0020, 0, 32'd0);
        push_d(0, 32'h5A1A_0020);
      end else begin
        push_g(1, 32'h1001_0004, 0, 32'd0);
        push_d(1, 32'h4A5B_0004);
      end
    end
    IAddress = 32'h0040_0020;
    IReq = 1'b1;
    DReq = 1'b1;
    dones = 0;
    for (int n = 0; n < 200 && dones < 10; n++) begin
      @(negedge Clock);
      if (IDone || DDone) dones++;
    end
    IReq = 1'b0;
    DReq = 1'b0;
    chk("contention_dones", dones, 10);

    // Eligibility: IReq kept high through IDone is regranted one cycle later.
    @(negedge Clock);
    push_g(0, 32'h0040_0010, 0, 32'd0);
    push_d(0, 32'h8C08_0004);
    push_g(0, 32'h0040_0010, 0, 32'd0);
    push_d(0, 32'h8C08_0004);
    IAddress = 32'h0040_0010;
    IReq = 1'b1;
    wait_done(0, "elig_first_done");
    @(negedge Clock);
    chk("elig_no_regrant", MemRequest, 0);
    @(negedge Clock);
    chk("elig_regrant", MemRequest, 1);
    wait_done(0, "elig_second_done");
    IReq = 1'b0;

    // Reset mid-access, then a fresh data grant after release.
    @(negedge Clock);
    tie_high = 1'b0;
    mem_delay = 1000;
    push_g(1, 32'h1001_0008, 1, 32'h1234_5678);
    DAddress = 32'h1001_0008; DWrite = 1'b1; DWriteData = 32'h1234_5678;
    DReq = 1'b1;
    repeat (3) @(negedge Clock);
    chk("mid_busy", Busy, 1);
    #2 NReset = 1'b0;
    #1;
    chk("arst_memreq", MemRequest, 0);
    chk("arst_memwrite", MemWrite, 0);
    chk("arst_busy", Busy, 0);
    chk("arst_memaddr", MemAddress, 0);
    chk("arst_memwdata", MemWriteData, 0);
    chk("arst_idata", IData, 0);
    chk("arst_dreaddata", DReadData, 0);
    chk("arst_dones", {IDone, DDone}, 0);
    @(negedge Clock);
    mem_delay = 0;
    DAddress = 32'h1001_000C; DWrite = 1'b0; DWriteData = 32'h0;
    push_g(1, 32'h1001_000C, 0, 32'd0);
    push_d(1, 32'h4A5B_000C);
    NReset = 1'b1;
    wait_done(1, "post_reset_done");
    DReq = 1'b0;

    repeat (3) @(negedge Clock);
    chk("gnt_q_empty", gnt_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_DATA_STREAK, default 4, meaning the maximum number of consecutive data grants while a fetch is pending; legal range 1..15.
REQ-002 SHALL have port Clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port NReset, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port IReq, input, 1, the instruction-fetch request, held high until IDone.
REQ-005 SHALL have port IAddress, input, 32, the fetch address, stable while IReq is high.
REQ-006 SHALL have port IDone, output, 1, a one-cycle pulse marking fetch completion.
REQ-007 SHALL have port IData, output, 32, the fetched word, valid while IDone is high.
REQ-008 SHALL have port DReq, input, 1, the data-access request, held high until DDone.
REQ-009 SHALL have port DWrite, input, 1, selecting write (1) or read (0), stable while DReq is high.
REQ-010 SHALL have port DAddress, input, 32, the data address, stable while DReq is high.
REQ-011 SHALL have port DWriteData, input, 32, the store data, stable while DReq is high.
REQ-012 SHALL have port DDone, output, 1, a one-cycle pulse marking data-access completion.
REQ-013 SHALL have port DReadData, output, 32, the load result, valid while DDone is high; it is 0 for writes.
REQ-014 SHALL have port MemRequest, output, 1, the request to the unified memory.
REQ-015 SHALL have port MemWrite, output, 1, the memory write enable, qualified by MemRequest.
REQ-016 SHALL have port MemAddress, output, 32, the memory address.
REQ-017 SHALL have port MemWriteData, output, 32, the memory store data.
REQ-018 SHALL have port MemReady, input, 1, memory completion, sampled only in a serving state.
REQ-019 SHALL have port MemReadData, input, 32, the memory read word, valid with MemReady.
REQ-020 SHALL have port Busy, output, 1, high in states INST and DATA.

Function
REQ-021 SHALL implement FSM states IDLE, INST and DATA; all outputs SHALL be registered.
REQ-022 IDLE, from IDLE with DReq eligible and (IReq not eligible, or streak < MAX_DATA_STREAK) -> DATA.
- The fetch address is latched to MemAddress; MemWrite=0; MemRequest=1.
- streak increments (saturating at MAX_DATA_STREAK) if IReq is high, otherwise clears to 0.
REQ-023 IDLE, from IDLE with IReq eligible and (DReq not eligible, or streak == MAX_DATA_STREAK) -> INST.
- IAddress is latched to MemAddress; MemWrite=0; MemRequest=1; streak clears to 0.
REQ-024 Eligibility: a requester whose Done output is high in the current cycle SHALL NOT be eligible for grant in that cycle.
REQ-025 In DATA, DAddress, DWrite and DWriteData SHALL be latched to MemAddress, MemWrite and MemWriteData at the grant edge; this correction to REQ-022 governs data grants.
REQ-026 INST/DATA with MemReady=0: the arbiter SHALL hold its state, with memory outputs unchanged; there is no timeout.
REQ-027 INST/DATA with MemReady=1: at the next edge -> IDLE, MemRequest=0, MemWrite=0, and IDone or DDone=1 for exactly one cycle.
- IData/DReadData = MemReadData as sampled (DReadData=0 if it was a write).
REQ-028 Latency: request sampled at edge k -> MemRequest high after edge k.
- MemReady sampled at edge k+1+n -> Done high after that edge.
- Minimum request-to-done is 2 cycles; back-to-back grants have 1 idle cycle between Done and the next MemRequest.
REQ-029 Request withdrawal in a serving state is illegal; the arbiter SHALL complete the access regardless.
REQ-030 IData and DReadData SHALL hold their values between completions; Done is the only qualifier.
REQ-031 Simultaneous IReq and DReq with streak < MAX SHALL grant data.
- Fetch is guaranteed a grant within MAX_DATA_STREAK+1 arbitration decisions.

Reset
REQ-032 NReset low SHALL immediately force state IDLE and streak=0.
- MemRequest, MemWrite, IDone, DDone and Busy SHALL be 0.
- MemAddress, MemWriteData, IData and DReadData SHALL be 0, including mid-access.
REQ-033 After NReset rises, the first grant decision SHALL occur at the first rising Clock edge with NReset high.
- A memory access interrupted by reset is not resumed.

Verification
REQ-034 Fetch only, IReq=1, IAddress=0x00400010, MemReady tied 1 -> MemRequest after 1 edge with MemAddress=0x00400010; IDone pulses with IData=MemReadData (0x8C080004).
REQ-035 Store, DReq=1, DWrite=1, DAddress=0x10010000, DWriteData=0xDEADBEEF, MemReady delayed 3 cycles -> MemWrite=1 held 4 cycles; DDone one cycle; DReadData=0.
REQ-036 Contention, IReq and DReq held high continuously with MemReady=1 -> grant order D,D,D,D,I,D,D,D,D,I; no Done is ever high for 2 consecutive cycles.
REQ-037 Reset mid-access, NReset low during DATA with MemReady=0 -> all outputs 0 asynchronously (before the next edge); after release with DReq=1, a fresh DATA grant.
REQ-038 Eligibility, IReq still high during the IDone cycle with DReq=0 -> no regrant in that cycle; if IReq is still high next cycle, INST is regranted.
REQ-039 MemReady=1 during IDLE -> ignored; no Done, no state change.
